trap_ctrl: RTL and testbench

- Pipeline sequencing controller for the fetch/decode/execute pipeline.
- Arbitrates redirect sources (EX jump, EX exception, mret, external interrupt) into the single br_taken/br_target pair consumed by the IF stage.
- Generates hold and flush controls for IF, ID and EX.
- Runs the multi-cycle machine-mode trap entry/exit sequence, writing mepc, mcause and mstatus through one CSR write port.

---
 rtl/trap_ctrl.sv | 166 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Brief    : Pipeline redirect arbiter, hold/flush generator and M-mode
//            trap entry / mret exit sequencer driving one CSR write port.
// Revision : 1.0
// ============================================================================
module trap_ctrl #(
    parameter int          RST_STATE_W    = 3,
    parameter logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_jump_req,
    input  logic [31:0] ex_jump_addr,
    input  logic        ex_exc_req,
    input  logic [31:0] ex_exc_pc,
    input  logic [31:0] ex_exc_cause,
    input  logic        mret_req,
    input  logic        int_req,
    input  logic [31:0] int_pc,
    input  logic        mem_stall,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    input  logic [31:0] csr_mstatus,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        hold_flag_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        trap_busy
);

    typedef enum logic [RST_STATE_W-1:0] {
        S_IDLE,
        S_SAVE_MEPC,
        S_SAVE_MCAUSE,
        S_SAVE_MSTATUS,
        S_RESTORE_MSTATUS,
        S_REDIRECT
    } state_t;

    localparam logic [11:0] C_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] C_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] C_ADDR_MCAUSE  = 12'h342;
    localparam logic        C_KIND_TRAP    = 1'b0;
    localparam logic        C_KIND_RET     = 1'b1;

    state_t      r_state;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_kind;

    logic w_idle;
    logic w_int_en;
    logic w_exc_start;
    logic w_ret_start;
    logic w_int_start;
    logic w_jump_only;
    logic w_start;

    // Fixed-priority arbitration of the IDLE-cycle request sources.
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_int_en    = int_req & csr_mstatus[3];
        w_exc_start = w_idle & ex_exc_req;
        w_ret_start = w_idle & ~ex_exc_req & mret_req;
        w_int_start = w_idle & ~ex_exc_req & ~mret_req & w_int_en;
        w_jump_only = w_idle & ~ex_exc_req & ~mret_req & ~w_int_en & ex_jump_req;
        w_start     = w_exc_start | w_ret_start | w_int_start;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mepc   <= 32'h0;
            r_mcause <= 32'h0;
            r_kind   <= C_KIND_TRAP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_exc_start) begin
                        r_mepc   <= ex_exc_pc;
                        r_mcause <= ex_exc_cause;
                        r_kind   <= C_KIND_TRAP;
                        r_state  <= S_SAVE_MEPC;
                    end else if (w_ret_start) begin
                        r_kind   <= C_KIND_RET;
                        r_state  <= S_RESTORE_MSTATUS;
                    end else if (w_int_start) begin
                        // A jump retiring alongside the interrupt is where execution resumes.
                        r_mepc   <= ex_jump_req ? ex_jump_addr : int_pc;
                        r_mcause <= MCAUSE_EXT_INT;
                        r_kind   <= C_KIND_TRAP;
                        r_state  <= S_SAVE_MEPC;
                    end
                end
                S_SAVE_MEPC:       r_state <= S_SAVE_MCAUSE;
                S_SAVE_MCAUSE:     r_state <= S_SAVE_MSTATUS;
                S_SAVE_MSTATUS:    r_state <= S_REDIRECT;
                S_RESTORE_MSTATUS: r_state <= S_REDIRECT;
                S_REDIRECT:        r_state <= S_IDLE;
                default:           r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by rst_n so an aborted sequence emits nothing in the reset cycle.
    always_comb begin
        br_taken     = 1'b0;
        br_target    = 32'h0;
        hold_flag_if = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        csr_we       = 1'b0;
        csr_waddr    = 12'h0;
        csr_wdata    = 32'h0;
        trap_busy    = 1'b0;
        if (rst_n) begin
            trap_busy    = ~w_idle;
            hold_flag_if = mem_stall | w_start | (~w_idle & (r_state != S_REDIRECT));
            flush_id     = ~w_idle | w_start | w_jump_only;
            flush_ex     = ~w_idle | w_start | w_jump_only;
            case (r_state)
                S_IDLE: begin
                    if (w_jump_only) begin
                        br_taken  = 1'b1;
                        br_target = ex_jump_addr;
                    end
                end
                S_SAVE_MEPC: begin
                    csr_we    = 1'b1;
                    csr_waddr = C_ADDR_MEPC;
                    csr_wdata = r_mepc;
                end
                S_SAVE_MCAUSE: begin
                    csr_we    = 1'b1;
                    csr_waddr = C_ADDR_MCAUSE;
                    csr_wdata = r_mcause;
                end
                S_SAVE_MSTATUS: begin
                    csr_we    = 1'b1;
                    csr_waddr = C_ADDR_MSTATUS;
                    csr_wdata = {csr_mstatus[31:8], csr_mstatus[3], csr_mstatus[6:4],
                                 1'b0, csr_mstatus[2:0]};
                end
                S_RESTORE_MSTATUS: begin
                    csr_we    = 1'b1;
                    csr_waddr = C_ADDR_MSTATUS;
                    csr_wdata = {csr_mstatus[31:8], 1'b1, csr_mstatus[6:4],
                                 csr_mstatus[7], csr_mstatus[2:0]};
                end
                S_REDIRECT: begin
                    br_taken  = 1'b1;
                    br_target = (r_kind == C_KIND_RET) ? csr_mepc : {csr_mtvec[31:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Brief    : Scoreboard bench for trap_ctrl: expected CSR writes and redirects
//            are queued with their cycle; a negedge monitor pops and compares.
// Revision : 1.0
// ============================================================================
module tb_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_jump_req;
    logic [31:0] ex_jump_addr;
    logic        ex_exc_req;
    logic [31:0] ex_exc_pc;
    logic [31:0] ex_exc_cause;
    logic        mret_req;
    logic        int_req;
    logic [31:0] int_pc;
    logic        mem_stall;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic [31:0] csr_mstatus;
    logic        br_taken;
    logic [31:0] br_target;
    logic        hold_flag_if;
    logic        flush_id;
    logic        flush_ex;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        trap_busy;

    trap_ctrl #(
        .RST_STATE_W    (3),
        .MCAUSE_EXT_INT (32'h8000_000B)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_jump_req  (ex_jump_req),
        .ex_jump_addr (ex_jump_addr),
        .ex_exc_req   (ex_exc_req),
        .ex_exc_pc    (ex_exc_pc),
        .ex_exc_cause (ex_exc_cause),
        .mret_req     (mret_req),
        .int_req      (int_req),
        .int_pc       (int_pc),
        .mem_stall    (mem_stall),
        .csr_mtvec    (csr_mtvec),
        .csr_mepc     (csr_mepc),
        .csr_mstatus  (csr_mstatus),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .hold_flag_if (hold_flag_if),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex),
        .csr_we       (csr_we),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .trap_busy    (trap_busy)
    );

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [31:0] data;
    } csr_ev_t;

    typedef struct {
        int          cyc;
        logic [31:0] target;
    } br_ev_t;

    csr_ev_t csr_q[$];
    br_ev_t  br_q[$];
    int      cyc;
    int      errors;
    int      checks;
    logic    mon_en;
    int      t0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sig_chk(input string name, input logic hold, input logic flush, input logic busy);
        chk({name, "_hold"},  {31'h0, hold_flag_if}, {31'h0, hold});
        chk({name, "_flush"}, {30'h0, flush_id, flush_ex}, {30'h0, flush, flush});
        chk({name, "_busy"},  {31'h0, trap_busy}, {31'h0, busy});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_csr(input int c, input logic [11:0] a, input logic [31:0] d);
        csr_ev_t e;
        e.cyc = c; e.addr = a; e.data = d;
        csr_q.push_back(e);
    endtask

    task automatic push_br(input int c, input logic [31:0] t);
        br_ev_t e;
        e.cyc = c; e.target = t;
        br_q.push_back(e);
    endtask

    task automatic clear_reqs();
        ex_jump_req = 1'b0; ex_exc_req = 1'b0; mret_req = 1'b0;
        int_req = 1'b0; mem_stall = 1'b0;
    endtask

    // Monitor: every CSR write / redirect must match the head of its queue, on the queued cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (csr_q.size() > 0 && csr_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL csr_missed: expected %h<=%h at cycle %0d was not observed", csr_q[0].addr, csr_q[0].data, csr_q[0].cyc);
                void'(csr_q.pop_front());
            end
            while (br_q.size() > 0 && br_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL br_missed: expected redirect %h at cycle %0d was not observed", br_q[0].target, br_q[0].cyc);
                void'(br_q.pop_front());
            end
            if (csr_we) begin
                checks++;
                if (csr_q.size() == 0) begin
                    errors++;
                    $display("FAIL csr_unexpected: got %h<=%h at cycle %0d, expected no write", csr_waddr, csr_wdata, cyc);
                end else if (csr_q[0].cyc != cyc || csr_q[0].addr !== csr_waddr || csr_q[0].data !== csr_wdata) begin
                    errors++;
                    $display("FAIL csr_write: got %h<=%h at cycle %0d, expected %h<=%h at cycle %0d",
                             csr_waddr, csr_wdata, cyc, csr_q[0].addr, csr_q[0].data, csr_q[0].cyc);
                    void'(csr_q.pop_front());
                end else begin
                    void'(csr_q.pop_front());
                end
            end else begin
                checks++;
                if (csr_waddr !== 12'h0 || csr_wdata !== 32'h0) begin
                    errors++;
                    $display("FAIL csr_idle_bus: got addr %h data %h, expected 0 0 (cycle %0d)", csr_waddr, csr_wdata, cyc);
                end
            end
            if (br_taken) begin
                checks++;
                if (br_q.size() == 0) begin
                    errors++;
                    $display("FAIL br_unexpected: got redirect %h at cycle %0d, expected none", br_target, cyc);
                end else if (br_q[0].cyc != cyc || br_q[0].target !== br_target) begin
                    errors++;
                    $display("FAIL br_redirect: got %h at cycle %0d, expected %h at cycle %0d",
                             br_target, cyc, br_q[0].target, br_q[0].cyc);
                    void'(br_q.pop_front());
                end else begin
                    void'(br_q.pop_front());
                end
            end
        end
    end

    initial begin
        errors = 0; checks = 0; mon_en = 1'b0;
        rst_n = 1'b0;
        clear_reqs();
        ex_jump_addr = '0; ex_exc_pc = '0; ex_exc_cause = '0; int_pc = '0;
        csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;

        // Reset state
        step();
        @(negedge clk);
        chk("reset_outs", {26'h0, br_taken, hold_flag_if, flush_id, flush_ex, csr_we, trap_busy}, 32'h0);
        step();
        rst_n = 1'b1; mon_en = 1'b1;
        @(negedge clk);
        sig_chk("idle", 1'b0, 1'b0, 1'b0);

        // Jump only: same-cycle redirect and flush, no sequence
        step();
        ex_jump_req = 1'b1; ex_jump_addr = 32'h100;
        push_br(cyc, 32'h100);
        @(negedge clk);
        sig_chk("jump", 1'b0, 1'b1, 1'b0);
        step();
        clear_reqs();
        @(negedge clk);
        sig_chk("jump_after", 1'b0, 1'b0, 1'b0);

        // ecall; a stray jump during the sequence must be ignored
        step();
        csr_mtvec = 32'h203; csr_mstatus = 32'h8;
        ex_exc_req = 1'b1; ex_exc_pc = 32'h40; ex_exc_cause = 32'd11;
        t0 = cyc;
        push_csr(t0 + 1, 12'h341, 32'h40);
        push_csr(t0 + 2, 12'h342, 32'hB);
        push_csr(t0 + 3, 12'h300, 32'h80);
        push_br(t0 + 4, 32'h200);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            if (k == 1) clear_reqs();
            if (k == 2) begin ex_jump_req = 1'b1; ex_jump_addr = 32'h999; end
            if (k == 3) clear_reqs();
            @(negedge clk);
            sig_chk($sformatf("ecall_t%0d", k), k < 4, k <= 4, k >= 1 && k <= 4);
        end

        // Interrupt with a simultaneous jump: the jump target becomes mepc
        step();
        csr_mstatus = 32'h8;
        int_req = 1'b1; ex_jump_req = 1'b1; ex_jump_addr = 32'h300; int_pc = 32'h50;
        t0 = cyc;
        push_csr(t0 + 1, 12'h341, 32'h300);
        push_csr(t0 + 2, 12'h342, 32'h8000_000B);
        push_csr(t0 + 3, 12'h300, 32'h80);
        push_br(t0 + 4, 32'h200);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            if (k == 1) clear_reqs();
            @(negedge clk);
            sig_chk($sformatf("irq_t%0d", k), k < 4, k <= 4, k >= 1 && k <= 4);
        end

        // Interrupt masked by MIE=0
        step();
        csr_mstatus = 32'h0; int_req = 1'b1; int_pc = 32'h50;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) step();
            @(negedge clk);
            sig_chk($sformatf("irq_masked_t%0d", k), 1'b0, 1'b0, 1'b0);
        end
        step();
        clear_reqs();

        // mret
        step();
        csr_mstatus = 32'h80; csr_mepc = 32'h300; mret_req = 1'b1;
        t0 = cyc;
        push_csr(t0 + 1, 12'h300, 32'h88);
        push_br(t0 + 2, 32'h300);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            if (k == 1) clear_reqs();
            @(negedge clk);
            sig_chk($sformatf("mret_t%0d", k), k < 2, k <= 2, k >= 1 && k <= 2);
        end

        // mret outranks an enabled interrupt
        step();
        csr_mstatus = 32'h88; csr_mepc = 32'h3C4; mret_req = 1'b1; int_req = 1'b1;
        t0 = cyc;
        push_csr(t0 + 1, 12'h300, 32'h88);
        push_br(t0 + 2, 32'h3C4);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            if (k == 1) clear_reqs();
            @(negedge clk);
            sig_chk($sformatf("mret_irq_t%0d", k), k < 2, k <= 2, k >= 1 && k <= 2);
        end

        // mem_stall with a jump: redirect still taken, IF held
        step();
        csr_mstatus = 32'h0; mem_stall = 1'b1; ex_jump_req = 1'b1; ex_jump_addr = 32'h444;
        push_br(cyc, 32'h444);
        @(negedge clk);
        sig_chk("stall_jump", 1'b1, 1'b1, 1'b0);
        step();
        ex_jump_req = 1'b0;
        @(negedge clk);
        sig_chk("stall_only", 1'b1, 1'b0, 1'b0);
        step();
        clear_reqs();

        // Reset during SAVE_MCAUSE aborts the rest of the sequence
        step();
        csr_mstatus = 32'h8; ex_exc_req = 1'b1; ex_exc_pc = 32'h80; ex_exc_cause = 32'd2;
        t0 = cyc;
        push_csr(t0 + 1, 12'h341, 32'h80);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            if (k == 1) clear_reqs();
            if (k == 2) rst_n = 1'b0;
            if (k == 3) rst_n = 1'b1;
            @(negedge clk);
            if (k < 2) sig_chk($sformatf("rst_seq_t%0d", k), 1'b1, 1'b1, k == 1);
            else       sig_chk($sformatf("rst_seq_t%0d", k), 1'b0, 1'b0, 1'b0);
        end

        step();
        step();
        @(negedge clk);
        chk("csr_q_drained", csr_q.size(), 32'd0);
        chk("br_q_drained",  br_q.size(),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
